// File: rtl/mbed_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : mbed_fifo_drain
// Description : Pops one FIFO word per synchronised MBED ready edge and shifts
//               it out as SPI master (mode 0), capturing the MISO word.
// Revision    : 1.0 - initial release
// ============================================================================
module mbed_fifo_drain #(
    parameter int DBITS       = 16,
    parameter int CLK_DIV     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             SYS_CLK,
    input  logic             RST_n,
    input  logic             MBED_RDY,
    input  logic             FIFO_EMPTY,
    input  logic [DBITS-1:0] FIFO_DOUT,
    output logic             FIFO_RD,
    input  logic             MISO,
    output logic             MOSI,
    output logic             SCK,
    output logic             CSbar,
    output logic             BUSY,
    output logic             FIN,
    output logic [DBITS-1:0] MISO_DATA,
    output logic [15:0]      WORD_COUNT
);

    localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_bit_w = $clog2(DBITS);
    localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DBITS - 1);
    localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_CS_SETUP = 3'd2,
        S_SHIFT    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rdy_d;
    logic                   w_rdy_edge;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_bit_w-1:0]     r_bit;
    logic                   w_tick;
    logic [DBITS-2:0]       r_tx;
    logic [DBITS-1:0]       r_rx;
    logic                   r_fifo_rd;
    logic                   r_mosi;
    logic                   r_sck;
    logic                   r_csbar;
    logic                   r_busy;
    logic                   r_fin;
    logic [DBITS-1:0]       r_miso_data;
    logic [15:0]            r_word_count;

    assign w_rdy_edge = r_sync[SYNC_STAGES-1] & ~r_rdy_d;
    assign w_tick     = (r_cnt == c_div_last);

    always_ff @(posedge SYS_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sync  <= '0;
            r_rdy_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], MBED_RDY};
            r_rdy_d <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_rdy_edge && !FIFO_EMPTY) w_state_nxt = S_LOAD;
            S_LOAD:     w_state_nxt = S_CS_SETUP;
            S_CS_SETUP: if (w_tick) w_state_nxt = S_SHIFT;
            S_SHIFT:    if (w_tick && !r_sck && (r_bit == c_bit_last)) w_state_nxt = S_DONE;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes and chip select are registered from the next state so every
    // output changes on the same edge as the state it belongs to.
    always_ff @(posedge SYS_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_fifo_rd    <= 1'b0;
            r_mosi       <= 1'b0;
            r_sck        <= 1'b0;
            r_csbar      <= 1'b1;
            r_busy       <= 1'b0;
            r_fin        <= 1'b0;
            r_miso_data  <= '0;
            r_word_count <= '0;
        end else begin
            r_fifo_rd <= (w_state_nxt == S_LOAD);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_fin     <= (w_state_nxt == S_DONE);
            r_csbar   <= !((w_state_nxt == S_CS_SETUP) || (w_state_nxt == S_SHIFT));
            case (r_state)
                S_LOAD: begin
                    r_tx   <= FIFO_DOUT[DBITS-2:0];
                    r_mosi <= FIFO_DOUT[DBITS-1];
                    r_cnt  <= '0;
                    r_bit  <= '0;
                    r_sck  <= 1'b0;
                end
                S_CS_SETUP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        r_sck <= 1'b1;
                        r_rx  <= {r_rx[DBITS-2:0], MISO};
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_SHIFT: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end else begin
                        r_cnt <= '0;
                        if (r_sck) begin
                            r_sck  <= 1'b0;
                            r_mosi <= r_tx[DBITS-2];
                            r_tx   <= r_tx << 1;
                        end else if (r_bit != c_bit_last) begin
                            r_bit <= r_bit + c_bit_one;
                            r_sck <= 1'b1;
                            r_rx  <= {r_rx[DBITS-2:0], MISO};
                        end else begin
                            // End of the CS hold phase: publish the frame.
                            r_mosi       <= 1'b0;
                            r_miso_data  <= r_rx;
                            r_word_count <= r_word_count + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign FIFO_RD    = r_fifo_rd;
    assign MOSI       = r_mosi;
    assign SCK        = r_sck;
    assign CSbar      = r_csbar;
    assign BUSY       = r_busy;
    assign FIN        = r_fin;
    assign MISO_DATA  = r_miso_data;
    assign WORD_COUNT = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_mbed_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbed_fifo_drain
// Description : Directed self-checking bench for mbed_fifo_drain with a FIFO
//               model and an SPI slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbed_fifo_drain;

    logic        SYS_CLK    = 1'b0;
    logic        RST_n      = 1'b0;
    logic        MBED_RDY   = 1'b0;
    logic        MISO       = 1'b0;
    logic        FIFO_EMPTY;
    logic [15:0] FIFO_DOUT;
    logic        FIFO_RD;
    logic        MOSI;
    logic        SCK;
    logic        CSbar;
    logic        BUSY;
    logic        FIN;
    logic [15:0] MISO_DATA;
    logic [15:0] WORD_COUNT;

    mbed_fifo_drain #(.DBITS(16), .CLK_DIV(4), .SYNC_STAGES(2)) dut (
        .SYS_CLK    (SYS_CLK),
        .RST_n      (RST_n),
        .MBED_RDY   (MBED_RDY),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DOUT  (FIFO_DOUT),
        .FIFO_RD    (FIFO_RD),
        .MISO       (MISO),
        .MOSI       (MOSI),
        .SCK        (SCK),
        .CSbar      (CSbar),
        .BUSY       (BUSY),
        .FIN        (FIN),
        .MISO_DATA  (MISO_DATA),
        .WORD_COUNT (WORD_COUNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Show-ahead FIFO model: the head advances on the falling edge after a pop.
    logic [15:0] mem [0:15];
    logic [3:0]  wr_ptr = 4'd0;
    logic [3:0]  rd_ptr = 4'd0;
    logic        prev_rd = 1'b0;
    assign FIFO_EMPTY = (wr_ptr == rd_ptr);
    assign FIFO_DOUT  = mem[rd_ptr];

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    int cyc = 0;
    int rdy_cyc = 0;
    int load_cyc = 0;
    int fin_cyc = 0;
    int rd_count = 0;
    int fin_count = 0;
    int cs_falls = 0;
    int sck_rise = 0;
    logic [15:0] miso_word = 16'h0000;
    logic [15:0] miso_sh = 16'h0000;
    logic [15:0] mosi_cap = 16'h0000;

    always @(posedge SYS_CLK) cyc++;

    always @(negedge SYS_CLK) begin
        if (prev_rd) rd_ptr = rd_ptr + 4'd1;
        prev_rd = FIFO_RD;
        if (FIFO_RD) begin
            rd_count++;
            load_cyc = cyc;
        end
        if (FIN) begin
            fin_count++;
            fin_cyc = cyc;
        end
    end

    // SPI slave: presents MSB at CS fall, advances on SCK fall, samples MOSI on SCK rise.
    always @(negedge CSbar) begin
        cs_falls++;
        miso_sh  = miso_word;
        MISO     = miso_sh[15];
        mosi_cap = 16'h0000;
        sck_rise = 0;
    end

    always @(negedge SCK) begin
        miso_sh = miso_sh << 1;
        MISO    = miso_sh[15];
    end

    always @(posedge SCK) begin
        mosi_cap = {mosi_cap[14:0], MOSI};
        sck_rise++;
    end

    task automatic pulse_rdy();
        @(negedge SYS_CLK);
        MBED_RDY = 1'b1;
        rdy_cyc  = cyc;
        repeat (6) @(negedge SYS_CLK);
        MBED_RDY = 1'b0;
    endtask

    task automatic wait_fin(input int base, input int budget);
        int n;
        n = 0;
        while (fin_count <= base && n < budget) begin
            @(negedge SYS_CLK);
            n++;
        end
        if (fin_count <= base) check("fin_timeout", fin_count, base + 1);
        repeat (2) @(negedge SYS_CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cs_base;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

        // Reset and idle
        repeat (3) @(negedge SYS_CLK);
        RST_n = 1'b1;
        repeat (20) @(negedge SYS_CLK);
        check("idle_fifo_rd",  FIFO_RD, 0);
        check("idle_mosi",     MOSI, 0);
        check("idle_sck",      SCK, 0);
        check("idle_csbar",    CSbar, 1);
        check("idle_busy",     BUSY, 0);
        check("idle_fin",      FIN, 0);
        check("idle_miso",     MISO_DATA, 16'h0000);
        check("idle_count",    WORD_COUNT, 16'h0000);
        check("idle_rd_count", rd_count, 0);

        // Basic frame
        push(16'hA5C3);
        miso_word = 16'h3C5A;
        pulse_rdy();
        wait_fin(0, 400);
        check("rd_latency",  load_cyc - rdy_cyc, 3);
        check("rd_pulses",   rd_count, 1);
        check("mosi_word",   mosi_cap, 16'hA5C3);
        check("fin_latency", fin_cyc - load_cyc, 133);
        check("fin_pulses",  fin_count, 1);
        check("miso_data",   MISO_DATA, 16'h3C5A);
        check("word_count",  WORD_COUNT, 1);
        check("post_csbar",  CSbar, 1);
        check("post_busy",   BUSY, 0);

        // Edge while FIFO empty is dropped
        pulse_rdy();
        repeat (200) @(negedge SYS_CLK);
        check("empty_rd",    rd_count, 1);
        check("empty_cs",    cs_falls, 1);
        check("empty_fin",   fin_count, 1);
        check("empty_count", WORD_COUNT, 1);

        // Edge mid-frame, then held high: one frame only
        push(16'h0F0F);
        push(16'h8001);
        miso_word = 16'h9696;
        pulse_rdy();
        repeat (40) @(negedge SYS_CLK);
        MBED_RDY = 1'b1;
        repeat (500) @(negedge SYS_CLK);
        check("hold_fin",   fin_count, 2);
        check("hold_rd",    rd_count, 2);
        check("hold_count", WORD_COUNT, 2);
        check("hold_mosi",  mosi_cap, 16'h0F0F);
        check("hold_miso",  MISO_DATA, 16'h9696);
        MBED_RDY = 1'b0;
        repeat (10) @(negedge SYS_CLK);
        miso_word = 16'h1357;
        pulse_rdy();
        wait_fin(2, 400);
        check("second_fin",   fin_count, 3);
        check("second_mosi",  mosi_cap, 16'h8001);
        check("second_miso",  MISO_DATA, 16'h1357);
        check("second_count", WORD_COUNT, 3);

        // Asynchronous reset at SHIFT bit 5
        push(16'h5555);
        push(16'h1234);
        miso_word = 16'hFFFF;
        cs_base = cs_falls;
        pulse_rdy();
        n = 0;
        while (!(cs_falls > cs_base && sck_rise >= 6) && n < 300) begin
            @(negedge SYS_CLK);
            n++;
        end
        check("bit5_reached", sck_rise, 6);
        RST_n = 1'b0;
        #1;
        check("rst_csbar", CSbar, 1);
        check("rst_sck",   SCK, 0);
        check("rst_busy",  BUSY, 0);
        repeat (5) @(negedge SYS_CLK);
        RST_n = 1'b1;
        repeat (5) @(negedge SYS_CLK);
        check("rst_fin",   fin_count, 3);
        check("rst_count", WORD_COUNT, 0);
        check("rst_miso",  MISO_DATA, 16'h0000);
        miso_word = 16'hC0DE;
        pulse_rdy();
        wait_fin(3, 400);
        check("after_rst_mosi",  mosi_cap, 16'h1234);
        check("after_rst_miso",  MISO_DATA, 16'hC0DE);
        check("after_rst_count", WORD_COUNT, 1);

        // Word counter wrap
        @(negedge SYS_CLK);
        force dut.r_word_count = 16'hFFFF;
        @(negedge SYS_CLK);
        release dut.r_word_count;
        @(negedge SYS_CLK);
        check("wrap_preload", WORD_COUNT, 16'hFFFF);
        push(16'h00FF);
        miso_word = 16'hA5A5;
        pulse_rdy();
        wait_fin(4, 400);
        check("wrap_count", WORD_COUNT, 16'h0000);
        check("wrap_fin",   fin_count, 5);
        check("wrap_mosi",  mosi_cap, 16'h00FF);
        check("wrap_miso",  MISO_DATA, 16'hA5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mbed_fifo_drain.md
# mbed_fifo_drain

Downstream consumer of the sample FIFO. On each rising edge of the MBED ready line it pops one word from the FIFO and shifts it out to the MBED over SPI as master. This replaces the ad-hoc ready-edge/SPI_ON glue and the separate SPI master in the top level with one self-contained, synchronised handshake engine. It also captures the word returned on MISO and counts completed transfers.

## Interface
- DBITS, 16, FIFO word width and SPI frame length in bits (≥2)
- CLK_DIV, 4, SCK half-period in SYS_CLK cycles (≥1)
- SYNC_STAGES, 2, synchroniser depth for MBED_RDY (≥2)

Ports:
- SYS_CLK  in  1  system clock (40 MHz)
- RST_n  in  1  asynchronous, active-low reset
- MBED_RDY  in  1  ready request from MBED GPIO; asynchronous to SYS_CLK
- FIFO_EMPTY  in  1  FIFO empty flag
- FIFO_DOUT  in  DBITS  FIFO head word; valid while FIFO_EMPTY=0
- FIFO_RD  out  1  one-cycle pop strobe
- MISO  in  1  SPI data from MBED
- MOSI  out  1  SPI data to MBED, MSB first
- SCK  out  1  SPI clock, mode 0 (idle low)
- CSbar  out  1  SPI chip select, active low
- BUSY  out  1  high from LOAD through DONE inclusive
- FIN  out  1  one-cycle pulse when a frame completes
- MISO_DATA  out  DBITS  last complete word received on MISO
- WORD_COUNT  out  16  number of completed frames

## Operation
- MBED_RDY passes through SYNC_STAGES flops, then a registered rising-edge detector, producing rdy_edge.
- FSM states: IDLE, LOAD, CS_SETUP, SHIFT, DONE.
- IDLE: if rdy_edge & ~FIFO_EMPTY, go to LOAD. Otherwise stay. An edge with FIFO_EMPTY=1 is dropped and does not pop.
- LOAD, 1 cycle: latch FIFO_DOUT into the tx shift register, assert FIFO_RD, and go to CS_SETUP.
- CS_SETUP, CLK_DIV cycles: CSbar=0, SCK=0, MOSI=tx[DBITS-1].
- SHIFT, DBITS bits, each 2·CLK_DIV cycles:
  - SCK high for CLK_DIV cycles. MISO is sampled into the rx register on the rising SCK cycle.
  - SCK low for CLK_DIV cycles. MOSI advances to the next bit on the high→low transition.
  - The low phase of the last bit is the CS hold time; CSbar stays 0 through it.
- DONE, 1 cycle: CSbar=1, FIN=1, MISO_DATA←rx, WORD_COUNT←WORD_COUNT+1 (wraps 0xFFFF→0), then IDLE.
- One frame per rdy_edge. Holding MBED_RDY high does not stream words.
- rdy_edge outside IDLE is ignored, not queued.
- The FIFO going empty or full during a frame has no effect, because the word is already latched.
- Reset asserted mid-frame (async):
  - outputs go to reset values immediately: CSbar=1, SCK=0, no FIN;
  - the popped word is lost;
  - WORD_COUNT is not incremented.

## Timing
- Reset values: FIFO_RD=0, MOSI=0, SCK=0, CSbar=1, BUSY=0, FIN=0, MISO_DATA=0, WORD_COUNT=0, FSM=IDLE, synchroniser and edge flops=0.
- MBED_RDY rise to LOAD: SYNC_STAGES+1 cycles, i.e. 3 cycles at the defaults.
- FIFO_RD is high exactly in the LOAD cycle. FIFO_DOUT is captured on that same cycle (show-ahead FIFO).
- LOAD to DONE: 1 + CLK_DIV + 2·CLK_DIV·DBITS cycles. At the defaults this is 133 cycles; FIN fires on cycle 134 counted from LOAD=1.
- SCK frequency is SYS_CLK/(2·CLK_DIV): 5 MHz at the defaults.
- The earliest following frame starts from the first IDLE cycle after DONE, and only on a fresh rdy_edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle with MBED_RDY=0 → all outputs hold their reset values. FIFO_RD is never asserted.
- FIFO holds 0xA5C3, MISO driven with 0x3C5A, MBED_RDY pulsed high → required response:
  - FIFO_RD pulses once, 3 cycles after the edge;
  - MOSI bits sampled on SCK rise read 0xA5C3 MSB first;
  - FIN pulses at LOAD+133;
  - MISO_DATA=0x3C5A and WORD_COUNT=1.
- MBED_RDY rises while FIFO_EMPTY=1 → no FIFO_RD, CSbar stays 1, FIN stays 0, WORD_COUNT unchanged.
- Second MBED_RDY edge mid-frame, then MBED_RDY held high for 500 cycles → exactly one frame and one FIN. A new edge after DONE produces a second frame.
- RST_n pulsed low at SHIFT bit 5 → CSbar=1 and SCK=0 within the same cycle, no FIN, WORD_COUNT=0. A following edge with a non-empty FIFO transfers the next word correctly.
- Preload WORD_COUNT to 0xFFFF via 65535 frames (or force), then run one more frame → WORD_COUNT=0x0000 and FIN pulses normally.
